// File: rtl/pipe_ctrl_pkg.sv
// ------------------------------------------------------------------
// pipe_ctrl_pkg : shared FSM encodings and defaults for pipe_ctrl.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2,
    ST_ISR    = 2'd3
  } state_t;

  localparam int CPU_WIDTH_DEF    = 16;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int REG_IDX_W        = 3;

  // Width needed to hold the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ------------------------------------------------------------------
// pipe_ctrl_if : pipeline-to-control hazard/interrupt signal bundle.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH = CPU_WIDTH_DEF
);
  logic [REG_IDX_W-1:0] ID_rs_idx;
  logic [REG_IDX_W-1:0] ID_rd_idx;
  logic                 ID_rs_use;
  logic                 ID_rd_use;
  logic [REG_IDX_W-1:0] EX_rd;
  logic                 EX_RegWe;
  logic                 EX_mem_ctrl;
  logic                 EX_branch;
  logic [CPU_WIDTH-1:0] EX_branch_target;
  logic [CPU_WIDTH-1:0] IF_pc;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 irq;
  logic                 int_en;
  logic                 ID_iret;

  logic                 hold_pc;
  logic                 hold_ifid;
  logic                 hold_idex;
  logic                 flush_ifid;
  logic                 id_kill;
  logic                 int_pc_sel;
  logic                 irq_ack;
  logic [CPU_WIDTH-1:0] epc;
  logic                 int_busy;

  modport master (
    output ID_rs_idx, ID_rd_idx, ID_rs_use, ID_rd_use, EX_rd, EX_RegWe,
           EX_mem_ctrl, EX_branch, EX_branch_target, IF_pc, mem_req,
           mem_ready, irq, int_en, ID_iret,
    input  hold_pc, hold_ifid, hold_idex, flush_ifid, id_kill,
           int_pc_sel, irq_ack, epc, int_busy
  );

  modport slave (
    input  ID_rs_idx, ID_rd_idx, ID_rs_use, ID_rd_use, EX_rd, EX_RegWe,
           EX_mem_ctrl, EX_branch, EX_branch_target, IF_pc, mem_req,
           mem_ready, irq, int_en, ID_iret,
    output hold_pc, hold_ifid, hold_idex, flush_ifid, id_kill,
           int_pc_sel, irq_ack, epc, int_busy
  );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// ------------------------------------------------------------------
// pipe_ctrl_hazard_detect : combinational load-use and memory-wait detect.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] ID_rs_idx,
  input  logic [REG_IDX_W-1:0] ID_rd_idx,
  input  logic                 ID_rs_use,
  input  logic                 ID_rd_use,
  input  logic [REG_IDX_W-1:0] EX_rd,
  input  logic                 EX_RegWe,
  input  logic                 EX_mem_ctrl,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 load_use,
  output logic                 mem_wait
);

  logic rs_hit;
  logic rd_hit;

  assign rs_hit   = ID_rs_use && (ID_rs_idx == EX_rd);
  assign rd_hit   = ID_rd_use && (ID_rd_idx == EX_rd);
  assign load_use = EX_mem_ctrl && EX_RegWe && (rs_hit || rd_hit);
  assign mem_wait = mem_req && !mem_ready;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ------------------------------------------------------------------
// pipe_ctrl : hazard stall/flush control and interrupt entry sequencing.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH    = CPU_WIDTH_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam int               CNT_W    = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CPU_WIDTH-1:0] epc_q, epc_d;

  logic load_use;
  logic mem_wait;
  logic adv;
  logic fsm_hold;
  logic fsm_vec;

  logic hold_pc_c, hold_ifid_c, hold_idex_c, flush_ifid_c, id_kill_c;
  logic int_pc_sel_c, irq_ack_c;

  pipe_ctrl_hazard_detect u_hazard (
    .ID_rs_idx   (bus.ID_rs_idx),
    .ID_rd_idx   (bus.ID_rd_idx),
    .ID_rs_use   (bus.ID_rs_use),
    .ID_rd_use   (bus.ID_rd_use),
    .EX_rd       (bus.EX_rd),
    .EX_RegWe    (bus.EX_RegWe),
    .EX_mem_ctrl (bus.EX_mem_ctrl),
    .mem_req     (bus.mem_req),
    .mem_ready   (bus.mem_ready),
    .load_use    (load_use),
    .mem_wait    (mem_wait)
  );

  // FSM steps that depend on the ID instruction moving forward (entry,
  // VECTOR completion, iret) wait until no hazard holds or kills it.
  assign adv = !mem_wait && !bus.EX_branch && !load_use;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    fsm_hold = 1'b0;
    fsm_vec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.irq && bus.int_en && adv) begin
          state_d = ST_DRAIN;
          epc_d   = bus.IF_pc;
          cnt_d   = CNT_INIT;
        end
      end
      ST_DRAIN: begin
        fsm_hold = 1'b1;
        if (!mem_wait) begin
          if (bus.EX_branch) begin
            epc_d = bus.EX_branch_target;
          end
          if (cnt_q == '0) begin
            state_d = ST_VECTOR;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_VECTOR: begin
        fsm_vec = 1'b1;
        if (adv) begin
          state_d = ST_ISR;
        end
      end
      ST_ISR: begin
        if (bus.ID_iret && adv) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_pc_c    = 1'b0;
    hold_ifid_c  = 1'b0;
    hold_idex_c  = 1'b0;
    flush_ifid_c = 1'b0;
    id_kill_c    = 1'b0;
    int_pc_sel_c = 1'b0;
    irq_ack_c    = 1'b0;
    if (mem_wait) begin
      hold_pc_c   = 1'b1;
      hold_ifid_c = 1'b1;
      hold_idex_c = 1'b1;
    end else if (bus.EX_branch) begin
      flush_ifid_c = 1'b1;
      id_kill_c    = 1'b1;
    end else if (load_use) begin
      hold_pc_c   = 1'b1;
      hold_ifid_c = 1'b1;
      id_kill_c   = 1'b1;
    end else begin
      hold_pc_c    = fsm_hold;
      hold_ifid_c  = fsm_hold;
      id_kill_c    = fsm_hold;
      flush_ifid_c = fsm_vec;
      int_pc_sel_c = fsm_vec;
      irq_ack_c    = fsm_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  assign bus.hold_pc    = rst_n && hold_pc_c;
  assign bus.hold_ifid  = rst_n && hold_ifid_c;
  assign bus.hold_idex  = rst_n && hold_idex_c;
  assign bus.flush_ifid = rst_n && flush_ifid_c;
  assign bus.id_kill    = rst_n && id_kill_c;
  assign bus.int_pc_sel = rst_n && int_pc_sel_c;
  assign bus.irq_ack    = rst_n && irq_ack_c;
  assign bus.int_busy   = rst_n && (state_q != ST_IDLE);
  assign bus.epc        = epc_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ------------------------------------------------------------------
// tb_pipe_ctrl : directed and randomized self-checking bench for pipe_ctrl.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

  localparam int W  = 16;
  localparam int DC = 3;

  bit   clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CPU_WIDTH(W)) bus ();

  pipe_ctrl #(.CPU_WIDTH(W), .DRAIN_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference: phase 0 idle, 1 draining, 2 vectoring, 3 in handler.
  int           m_phase;
  int           m_left;
  logic [W-1:0] m_epc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit f_mw();
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic bit f_lu();
    return bus.EX_mem_ctrl && bus.EX_RegWe &&
           ((bus.ID_rs_use && bus.ID_rs_idx == bus.EX_rd) ||
            (bus.ID_rd_use && bus.ID_rd_idx == bus.EX_rd));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit mw, lu, adv;
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_epc   <= '0;
    end else begin
      mw  = f_mw();
      lu  = f_lu();
      adv = !mw && !bus.EX_branch && !lu;
      case (m_phase)
        0: if (bus.irq && bus.int_en && adv) begin
             m_phase <= 1;
             m_left  <= DC;
             m_epc   <= bus.IF_pc;
           end
        1: if (!mw) begin
             if (bus.EX_branch) m_epc <= bus.EX_branch_target;
             if (m_left == 1) m_phase <= 2;
             m_left <= m_left - 1;
           end
        2: if (adv) m_phase <= 3;
        3: if (bus.ID_iret && adv) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Expected outputs from the priority rules applied to the current phase.
  always @(negedge clk) begin
    bit e_hpc, e_hifid, e_hidex, e_flush, e_kill, e_sel, e_ack, e_busy;
    if (cmp_en) begin
      {e_hpc, e_hifid, e_hidex, e_flush, e_kill, e_sel, e_ack, e_busy} = '0;
      if (rst_n) begin
        e_busy = (m_phase != 0);
        if (f_mw()) begin
          e_hpc = 1; e_hifid = 1; e_hidex = 1;
        end else if (bus.EX_branch) begin
          e_flush = 1; e_kill = 1;
        end else if (f_lu()) begin
          e_hpc = 1; e_hifid = 1; e_kill = 1;
        end else if (m_phase == 1) begin
          e_hpc = 1; e_hifid = 1; e_kill = 1;
        end else if (m_phase == 2) begin
          e_flush = 1; e_sel = 1; e_ack = 1;
        end
      end
      chk("hold_pc",    bus.hold_pc,    e_hpc);
      chk("hold_ifid",  bus.hold_ifid,  e_hifid);
      chk("hold_idex",  bus.hold_idex,  e_hidex);
      chk("flush_ifid", bus.flush_ifid, e_flush);
      chk("id_kill",    bus.id_kill,    e_kill);
      chk("int_pc_sel", bus.int_pc_sel, e_sel);
      chk("irq_ack",    bus.irq_ack,    e_ack);
      chk("int_busy",   bus.int_busy,   e_busy);
      chk("epc",        bus.epc,        m_epc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.ID_rs_idx = '0; bus.ID_rd_idx = '0; bus.ID_rs_use = 0; bus.ID_rd_use = 0;
    bus.EX_rd = '0; bus.EX_RegWe = 0; bus.EX_mem_ctrl = 0; bus.EX_branch = 0;
    bus.EX_branch_target = '0; bus.IF_pc = '0; bus.mem_req = 0; bus.mem_ready = 0;
    bus.irq = 0; bus.int_en = 0; bus.ID_iret = 0;
  endtask

  task automatic set_load_use();
    bus.EX_mem_ctrl = 1; bus.EX_RegWe = 1; bus.EX_rd = 3'd3;
    bus.ID_rs_idx = 3'd3; bus.ID_rs_use = 1;
  endtask

  int acks = 0;

  initial begin
    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    mid();
    chk("rst_epc", bus.epc, 16'h0000);
    chk("rst_busy", bus.int_busy, 1'b0);
    tick();
    rst_n = 1'b1;

    // load-use, then same operands without the read
    tick();
    set_load_use();
    mid();
    chk("lu_hold_pc", bus.hold_pc, 1'b1);
    chk("lu_hold_ifid", bus.hold_ifid, 1'b1);
    chk("lu_id_kill", bus.id_kill, 1'b1);
    chk("lu_hold_idex", bus.hold_idex, 1'b0);
    tick();
    bus.ID_rs_use = 0;
    mid();
    chk("nolu_hold_pc", bus.hold_pc, 1'b0);
    chk("nolu_id_kill", bus.id_kill, 1'b0);

    // 4-cycle memory wait masking a pending load-use
    tick();
    set_load_use();
    bus.mem_req = 1; bus.mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("mw_hold_idex", bus.hold_idex, 1'b1);
      chk("mw_id_kill", bus.id_kill, 1'b0);
      tick();
    end
    bus.mem_ready = 1;
    mid();
    chk("mw_end_hold_idex", bus.hold_idex, 1'b0);
    chk("mw_end_lu_kill", bus.id_kill, 1'b1);

    // branch together with load-use
    tick();
    bus.mem_req = 0; bus.mem_ready = 0;
    bus.EX_branch = 1;
    mid();
    chk("br_flush", bus.flush_ifid, 1'b1);
    chk("br_kill", bus.id_kill, 1'b1);
    chk("br_hold_pc", bus.hold_pc, 1'b0);
    tick();
    set_idle();
    mid();
    chk("br_after_flush", bus.flush_ifid, 1'b0);

    // interrupt entry from IF_pc 0x0040
    tick();
    bus.int_en = 1; bus.irq = 1; bus.IF_pc = 16'h0040;
    mid();
    chk("ie_busy_before", bus.int_busy, 1'b0);
    tick();
    bus.irq = 0; bus.IF_pc = 16'h1234;
    for (int i = 0; i < DC; i++) begin
      mid();
      chk("ie_drain_kill", bus.id_kill, 1'b1);
      chk("ie_drain_ack", bus.irq_ack, 1'b0);
      chk("ie_epc", bus.epc, 16'h0040);
      tick();
    end
    mid();
    chk("ie_ack", bus.irq_ack, 1'b1);
    chk("ie_pc_sel", bus.int_pc_sel, 1'b1);
    tick();
    bus.irq = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("ie_isr_ack", bus.irq_ack, 1'b0);
      chk("ie_isr_busy", bus.int_busy, 1'b1);
      tick();
    end
    bus.irq = 0; bus.ID_iret = 1;
    tick();
    bus.ID_iret = 0;
    mid();
    chk("ie_iret_busy", bus.int_busy, 1'b0);

    // branch in drain cycle 2, then a 2-cycle wait: ack 6 cycles after entry
    tick();
    bus.irq = 1; bus.IF_pc = 16'h0200;
    tick();
    bus.irq = 0;
    for (int k = 0; k < 6; k++) begin
      bus.EX_branch = (k == 1);
      bus.EX_branch_target = (k == 1) ? 16'h0100 : 16'h0000;
      bus.mem_req = (k == 2 || k == 3);
      bus.mem_ready = 0;
      mid();
      chk("bd_ack", bus.irq_ack, (k == 5));
      if (k == 2) chk("bd_epc", bus.epc, 16'h0100);
      if (k == 3) chk("bd_mw_kill", bus.id_kill, 1'b0);
      tick();
    end

    // asynchronous reset while in the handler
    set_idle();
    bus.mem_req = 1;
    bus.EX_branch = 1;
    mid();
    chk("rs_busy_pre", bus.int_busy, 1'b1);
    tick();
    rst_n = 0;
    #1;
    chk("rs_busy", bus.int_busy, 1'b0);
    chk("rs_hold_idex", bus.hold_idex, 1'b0);
    chk("rs_flush", bus.flush_ifid, 1'b0);
    chk("rs_epc", bus.epc, 16'h0000);
    tick();
    rst_n = 1;
    set_idle();
    bus.irq = 1; bus.int_en = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("rs_no_entry", bus.int_busy, 1'b0);
      tick();
    end

    // randomized traffic checked against the reference every cycle
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      bus.ID_rs_idx        = 3'($urandom_range(0, 3));
      bus.ID_rd_idx        = 3'($urandom_range(0, 3));
      bus.ID_rs_use        = ($urandom_range(0, 1) == 1);
      bus.ID_rd_use        = ($urandom_range(0, 2) == 0);
      bus.EX_rd            = 3'($urandom_range(0, 3));
      bus.EX_RegWe         = ($urandom_range(0, 9) < 7);
      bus.EX_mem_ctrl      = ($urandom_range(0, 9) < 3);
      bus.EX_branch        = ($urandom_range(0, 9) == 0);
      bus.EX_branch_target = 16'($urandom);
      bus.IF_pc            = 16'($urandom);
      bus.mem_req          = ($urandom_range(0, 4) == 0);
      bus.mem_ready        = ($urandom_range(0, 1) == 1);
      bus.irq              = ($urandom_range(0, 9) < 3);
      bus.int_en           = ($urandom_range(0, 9) < 7);
      bus.ID_iret          = ($urandom_range(0, 9) == 0);
      mid();
      if (bus.irq_ack) acks++;
      tick();
    end
    rst_n = 1;
    chk("rand_acks_seen", (acks > 0), 1'b1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
